fp_minmax_reduce: RTL

FP_MINMAX_REDUCE -- requirements
Module: fp_minmax_reduce

---
 rtl/fp_minmax_reduce.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fp_minmax_reduce.sv
// Streaming sign-magnitude float min/max reduction with winner index; optional NaN-aware mode via FP_MINMAX_NAN_EN.
// Latency: result registered 1 cycle after the in_last beat is accepted.
// Backpressure: in_ready drops while a result waits in HOLD; out_data/out_idx hold until out_ready.
module fp_minmax_reduce #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int IDX_W = 8,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [IDX_W-1:0] out_idx
`ifdef FP_MINMAX_NAN_EN
    ,
    output logic             out_nan
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    state_t           state;
    logic [W-1:0]     best;
    logic [IDX_W-1:0] best_idx;
    logic [IDX_W-1:0] cnt;
    logic             mode_q;

    logic             accept;
    logic             first;
    logic             better;
    logic             take;
    logic [W-1:0]     nxt_best;
    logic [IDX_W-1:0] nxt_idx;

    // a < b under sign-magnitude ordering; -0 sorts below +0, infinities are plain extremes
    function automatic logic fp_lt(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-2:0] ma;
        logic [W-2:0] mb;
        ma = a[W-2:0];
        mb = b[W-2:0];
        if (a[W-1] != b[W-1])
            return a[W-1];
        else if (a[W-1])
            return ma > mb;
        else
            return ma < mb;
    endfunction

`ifdef FP_MINMAX_NAN_EN
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic best_nan;
    logic in_nan;
    logic nxt_nan;

    function automatic logic is_nan(input logic [W-1:0] a);
        return (a[W-2 -: EXP_W] == {EXP_W{1'b1}}) && (a[MAN_W-1:0] != '0);
    endfunction
`endif

    assign in_ready = (state != HOLD);
    assign accept   = in_valid & in_ready;
    assign first    = (state == IDLE);

    always_comb begin
        better = mode_q ? fp_lt(best, in_data) : fp_lt(in_data, best);
`ifdef FP_MINMAX_NAN_EN
        in_nan = is_nan(in_data);
        // a NaN never displaces a number, a number always displaces a NaN
        if (first)
            take = 1'b1;
        else if (best_nan)
            take = !in_nan;
        else
            take = !in_nan && better;
        nxt_nan = take ? in_nan : best_nan;
`else
        take = first | better;
`endif
        nxt_best = take ? in_data : best;
        nxt_idx  = first ? '0 : (take ? cnt : best_idx);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            best      <= '0;
            best_idx  <= '0;
            cnt       <= '0;
            mode_q    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
`ifdef FP_MINMAX_NAN_EN
            best_nan  <= 1'b0;
            out_nan   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (accept) begin
                        best     <= nxt_best;
                        best_idx <= nxt_idx;
                        cnt      <= first ? IDX_ONE : cnt + IDX_ONE;
                        if (first)
                            mode_q <= mode;
`ifdef FP_MINMAX_NAN_EN
                        best_nan <= nxt_nan;
`endif
                        if (in_last) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
`ifdef FP_MINMAX_NAN_EN
                            out_data  <= nxt_nan ? QNAN : nxt_best;
                            out_idx   <= nxt_nan ? '0 : nxt_idx;
                            out_nan   <= nxt_nan;
`else
                            out_data  <= nxt_best;
                            out_idx   <= nxt_idx;
`endif
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
